lea_key_sched_ctrl: RTL and testbench
=====================================

# lea_key_sched_ctrl

Sequential LEA-128 key-schedule engine: accepts a 128-bit key over a valid/ready handshake. Produces the 24 round keys RK0..RK23 one per transfer on a backpressured output stream. A single shared word-update datapath is reused across rounds, replacing the fully unrolled 24-instance schedule. It sits between the key-load interface and the round datapath of the cipher core.

## Interface
- NUM_ROUNDS, 24, round keys per key load (LEA-128).
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- key  in  128  cipher key; key[31:0]=T0, key[63:32]=T1, key[95:64]=T2, key[127:96]=T3 (little-endian words).
- key_valid  in  1  key present.
- key_ready  out  1  block idle, key will be captured.
- abort  in  1  synchronous cancel of the schedule in progress.
- rk  out  192  round key {T1,T3,T1,T2,T1,T0} (rk[31:0]=T0, rk[63:32]=T1, rk[95:64]=T2, rk[127:96]=T1, rk[159:128]=T3, rk[191:160]=T1).
- rk_idx  out  5  index i of the round key on rk.
- rk_valid  out  1  rk/rk_idx valid.
- rk_ready  in  1  consumer accepts rk.
- busy  out  1  schedule in progress.
- done  out  1  one-cycle pulse after RK23 transfers.

## Operation
- Per-round update for round i (0..23), with d = DELTA[i mod 4]:
  - T0 = ROL1(T0 + ROLi(d))
  - T1 = ROL3(T1 + ROL(i+1)(d))
  - T2 = ROL6(T2 + ROL(i+2)(d))
  - T3 = ROL11(T3 + ROL(i+3)(d))
- All additions are mod 2^32; rotate amounts are taken mod 32.
- DELTA = {0xc3efe9db, 0x44626b02, 0x79e27c8a, 0x78df30ec}.
- States:
  - IDLE: key_ready=1. key_valid&&key_ready stores round 0 of key into T0..T3 and moves to RUN.
  - RUN: rk_valid=1, busy=1. On rk_valid&&rk_ready with rk_idx<23, apply round rk_idx+1 to T and increment rk_idx. With rk_idx==23, go to DONE.
  - DONE: done=1, rk_valid=0, busy=0. Always returns to IDLE next cycle.
- key_ready is high only in IDLE. A key offered in DONE waits one cycle.
- rk and rk_idx hold stable while rk_valid&&!rk_ready.
- abort in RUN: go to IDLE next cycle, no done pulse, rk_idx cleared, T registers cleared to 0.
  - abort coinciding with a handshake: the transfer counts, no further rounds.
  - abort in IDLE or DONE has no effect.
- rst mid-schedule: everything returns to reset values immediately and the key is discarded.

## Timing
- Reset values: key_ready=1, rk_valid=0, rk=0, rk_idx=0, busy=0, done=0, state IDLE.
- Key accepted at edge t: RK0 valid from t+1.
- With rk_ready held high: RKi appears at cycle t+1+i, done pulses at t+25, key_ready is high again at t+26.
- Throughput is 1 round key per cycle. Each rk_ready-low cycle adds 1 cycle of latency.
- Combinational paths:
  - key_ready depends on state only.
  - No combinational path from rk_ready or key_valid to any output.

## Structure
- Package lea_pkg:
  - LEA_DELTA[0:3], ROT_T = {1,3,6,11}, NUM_ROUNDS=24.
  - rk_t, a packed struct of six 32-bit words in the rk order above.
- Sub-module lea_ks_step (combinational): inputs T[127:0] and round index i[4:0]; output is the updated T[127:0].
  - Contains four word lanes of rotate-delta / add / rotate.
  - Instantiated once and fed either key (on load) or the T registers (in RUN).
- Controller contains the FSM, T registers, rk_idx counter and output registers.

## Test plan
- Reset: assert rst asynchronously mid-cycle -> all outputs at reset values immediately; key_ready=1.
- Known answer, rk_ready=1:
  - key = 0xf0e1d2c3b4a5968778695a4b3c2d1e0f (bytes 0f 1e 2d ... f0).
  - RK0 words T0..T5 = 0x003a0fd4, 0x02497010, 0x194f7db1, 0x02497010, 0x090d0883, 0x02497010.
  - All 24 keys match the software model; done pulses at t+25.
- Backpressure: rk_ready random 50%.
  - rk/rk_idx stable while stalled, no index skipped or duplicated.
  - Same 24 values as the known-answer case.
- Abort at rk_idx=10 with rk_ready=1 -> RK10 transferred, rk_valid=0 next cycle, no done, key_ready=1. A new key then restarts at RK0 with correct values.
- Back-to-back keys: key_valid held high with a second key -> second key accepted exactly one cycle after the done pulse; its RK0 appears the following cycle.
- Reset during RUN at rk_idx=5 -> rk_valid drops immediately; next key produces a correct schedule from RK0.

Source files
------------

// File: rtl/lea_pkg.sv
// LEA-128 key-schedule constants, round-key word layout and a 32-bit rotate helper.
package lea_pkg;

   localparam int unsigned NUM_ROUNDS = 24;
   localparam int unsigned IDX_W      = 5;

   localparam logic [31:0] LEA_DELTA [0:3] = '{
      32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec
   };

   localparam int unsigned ROT_T [0:3] = '{1, 3, 6, 11};

   // First member lands in the top word: rk = {T1,T3,T1,T2,T1,T0}.
   typedef struct packed {
      logic [31:0] t1_hi;
      logic [31:0] t3;
      logic [31:0] t1_mid;
      logic [31:0] t2;
      logic [31:0] t1_lo;
      logic [31:0] t0;
   } rk_t;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } ks_state_e;

   function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] s);
      return (x << s) | (x >> (6'd32 - {1'b0, s}));
   endfunction

   function automatic rk_t pack_rk(input logic [127:0] t);
      rk_t r;
      r.t0     = t[31:0];
      r.t1_lo  = t[63:32];
      r.t2     = t[95:64];
      r.t1_mid = t[63:32];
      r.t3     = t[127:96];
      r.t1_hi  = t[63:32];
      return r;
   endfunction

endpackage

// File: rtl/lea_key_sched_ctrl_if.sv
// Key-load and round-key stream handshakes of the LEA-128 key-schedule engine.
interface lea_key_sched_ctrl_if;

   logic [127:0]       key;
   logic               key_valid;
   logic               key_ready;
   lea_pkg::rk_t       rk;
   logic [4:0]         rk_idx;
   logic               rk_valid;
   logic               rk_ready;

   modport master (
      output key, key_valid, rk_ready,
      input  key_ready, rk, rk_idx, rk_valid
   );

   modport slave (
      input  key, key_valid, rk_ready,
      output key_ready, rk, rk_idx, rk_valid
   );

endinterface

// File: rtl/lea_ks_step.sv
// One LEA-128 key-schedule round: four rotate-delta / add / rotate word lanes.
module lea_ks_step
   import lea_pkg::*;
(
   input  logic [127:0] t,
   input  logic [4:0]   i,
   output logic [127:0] t_next
);

   logic [31:0] d;

   assign d = LEA_DELTA[i[1:0]];

   for (genvar j = 0; j < 4; j++) begin : g_lane
      logic [4:0]  amt;
      logic [31:0] sum;

      // 5-bit add wraps the delta rotate amount mod 32.
      assign amt = i + 5'(j);
      assign sum = t[32*j +: 32] + rol32(d, amt);
      assign t_next[32*j +: 32] = rol32(sum, 5'(ROT_T[j]));
   end

endmodule

// File: rtl/lea_key_sched_ctrl.sv
// Sequential LEA-128 key schedule: one shared round step, RK0..RK23 streamed with backpressure.
module lea_key_sched_ctrl
   import lea_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   lea_key_sched_ctrl_if.slave  ks,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done
);

   ks_state_e    state;
   logic [127:0] t_reg;
   logic [4:0]   idx;
   logic         rk_valid_reg;
   logic         key_ready_reg;
   logic         busy_reg;
   logic         done_reg;

   logic [127:0] step_in;
   logic [127:0] step_out;
   logic [4:0]   step_i;
   logic         last;

   // The step is fed the key for round 0 on load, and the T registers for later rounds.
   assign step_in = (state == StIdle) ? ks.key : t_reg;
   assign step_i  = (state == StIdle) ? 5'd0 : idx + 5'd1;
   assign last    = (idx == 5'(NUM_ROUNDS - 1));

   lea_ks_step u_step (
      .t      (step_in),
      .i      (step_i),
      .t_next (step_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= StIdle;
         t_reg         <= '0;
         idx           <= '0;
         rk_valid_reg  <= 1'b0;
         key_ready_reg <= 1'b1;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state)
            StIdle: begin
               if (ks.key_valid) begin
                  state         <= StRun;
                  t_reg         <= step_out;
                  idx           <= '0;
                  rk_valid_reg  <= 1'b1;
                  key_ready_reg <= 1'b0;
                  busy_reg      <= 1'b1;
               end
            end
            StRun: begin
               // Abort wins over advancing; a coincident handshake still counts as transferred.
               if (abort) begin
                  state         <= StIdle;
                  t_reg         <= '0;
                  idx           <= '0;
                  rk_valid_reg  <= 1'b0;
                  key_ready_reg <= 1'b1;
                  busy_reg      <= 1'b0;
               end else if (ks.rk_ready) begin
                  if (last) begin
                     state        <= StDone;
                     rk_valid_reg <= 1'b0;
                     busy_reg     <= 1'b0;
                     done_reg     <= 1'b1;
                  end else begin
                     t_reg <= step_out;
                     idx   <= idx + 5'd1;
                  end
               end
            end
            StDone: begin
               state         <= StIdle;
               idx           <= '0;
               key_ready_reg <= 1'b1;
            end
            default: begin
               state         <= StIdle;
               rk_valid_reg  <= 1'b0;
               key_ready_reg <= 1'b1;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   assign ks.rk        = pack_rk(t_reg);
   assign ks.rk_idx    = idx;
   assign ks.rk_valid  = rk_valid_reg;
   assign ks.key_ready = key_ready_reg;
   assign busy         = busy_reg;
   assign done         = done_reg;

endmodule

// File: tb/tb_lea_key_sched_ctrl.sv
// Directed bench for lea_key_sched_ctrl: known answer, backpressure, abort, back-to-back, reset.
module tb_lea_key_sched_ctrl;

   localparam logic [127:0] KAT_KEY = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
   localparam logic [191:0] KAT_RK0 = {32'h02497010, 32'h090d0883, 32'h02497010,
                                       32'h194f7db1, 32'h02497010, 32'h003a0fd4};
   localparam logic [127:0] KEY_B   = 128'h0123456789abcdef_fedcba9876543210;
   localparam logic [127:0] KEY_C   = 128'hdeadbeef_00000000_ffffffff_13579bdf;

   logic clk = 1'b0;
   logic rst;
   logic abort;
   logic busy;
   logic done;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0]  delta [4] = '{32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec};
   logic [191:0] exp_rk [24];

   lea_key_sched_ctrl_if ifc ();

   lea_key_sched_ctrl dut (
      .clk   (clk),
      .rst   (rst),
      .ks    (ifc),
      .abort (abort),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
      logic [63:0] w;
      int          r;
      r = s % 32;
      w = {x, x};
      return w[63-r -: 32];
   endfunction

   task automatic gen_expected(input logic [127:0] k);
      logic [31:0] t [4];
      logic [31:0] d;
      for (int w = 0; w < 4; w++) t[w] = k[32*w +: 32];
      for (int r = 0; r < 24; r++) begin
         d    = delta[r % 4];
         t[0] = rotl(t[0] + rotl(d, r), 1);
         t[1] = rotl(t[1] + rotl(d, r + 1), 3);
         t[2] = rotl(t[2] + rotl(d, r + 2), 6);
         t[3] = rotl(t[3] + rotl(d, r + 3), 11);
         exp_rk[r] = {t[1], t[3], t[1], t[2], t[1], t[0]};
      end
   endtask

   // Called at a negedge. Loads k, consumes the stream with rk_ready high pct% of cycles.
   task automatic run_key(input logic [127:0] k, input int pct, input int abort_at,
                          input int rst_at, input bit hold, input logic [127:0] next_k);
      int idx;
      int cyc;
      int waitc;
      bit fire;
      bit aborted;
      gen_expected(k);
      ifc.key       = k;
      ifc.key_valid = 1'b1;
      waitc = 0;
      while (!ifc.key_ready && waitc < 40) begin
         @(negedge clk);
         waitc++;
      end
      check("load_ready", ifc.key_ready, 1'b1);
      @(negedge clk);
      ifc.key       = next_k;
      ifc.key_valid = hold;
      idx     = 0;
      cyc     = 1;
      aborted = 1'b0;
      while (cyc < 400 && ifc.rk_valid && idx < 24 && !aborted) begin
         check("rk_idx", ifc.rk_idx, idx);
         check("rk_val", ifc.rk, exp_rk[idx]);
         check("busy_run", busy, 1'b1);
         if (idx == 0 && k == KAT_KEY) check("kat_rk0", ifc.rk, KAT_RK0);
         if (idx == rst_at) begin
            #2 rst = 1'b1;
            #1;
            check("rst_valid", ifc.rk_valid, 1'b0);
            check("rst_rk", ifc.rk, '0);
            check("rst_idx", ifc.rk_idx, '0);
            check("rst_key_ready", ifc.key_ready, 1'b1);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
            @(negedge clk);
            rst = 1'b0;
            ifc.rk_ready = 1'b0;
            return;
         end
         fire = (idx == abort_at) || ($urandom_range(99) < pct);
         ifc.rk_ready = fire;
         abort = (idx == abort_at);
         @(negedge clk);
         cyc++;
         abort = 1'b0;
         if (fire) begin
            aborted = (idx == abort_at);
            idx++;
         end
      end
      ifc.rk_ready = 1'b0;
      if (aborted) begin
         check("abort_count", idx, abort_at + 1);
         check("abort_valid", ifc.rk_valid, 1'b0);
         check("abort_done", done, 1'b0);
         check("abort_key_ready", ifc.key_ready, 1'b1);
         check("abort_busy", busy, 1'b0);
         check("abort_rk", ifc.rk, '0);
         check("abort_idx", ifc.rk_idx, '0);
         @(negedge clk);
         check("abort_no_done", done, 1'b0);
      end else begin
         check("rk_count", idx, 24);
         check("done_pulse", done, 1'b1);
         check("done_valid", ifc.rk_valid, 1'b0);
         check("done_busy", busy, 1'b0);
         check("done_key_ready", ifc.key_ready, 1'b0);
         if (pct == 100) check("done_latency", cyc, 25);
         @(negedge clk);
         check("done_clear", done, 1'b0);
         check("idle_key_ready", ifc.key_ready, 1'b1);
      end
   endtask

   initial begin
      rst           = 1'b1;
      abort         = 1'b0;
      ifc.key       = '0;
      ifc.key_valid = 1'b0;
      ifc.rk_ready  = 1'b0;
      #3;
      check("reset_key_ready", ifc.key_ready, 1'b1);
      check("reset_valid", ifc.rk_valid, 1'b0);
      check("reset_rk", ifc.rk, '0);
      check("reset_idx", ifc.rk_idx, '0);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("idle_abort_ready", ifc.key_ready, 1'b1);
      check("idle_abort_busy", busy, 1'b0);

      run_key(KAT_KEY, 100, -1, -1, 1'b0, '0);
      run_key(KAT_KEY, 50, -1, -1, 1'b0, '0);
      run_key(KEY_B, 100, 10, -1, 1'b0, '0);
      run_key(KAT_KEY, 100, -1, -1, 1'b0, '0);
      run_key(KEY_B, 100, -1, -1, 1'b1, KEY_C);
      check("b2b_key_ready", ifc.key_ready, 1'b1);
      run_key(KEY_C, 100, -1, -1, 1'b0, '0);
      run_key(KEY_C, 100, -1, 5, 1'b0, '0);
      run_key(KEY_C, 70, -1, -1, 1'b0, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
